// File: rtl/float2int_pkg.sv
// Shared types and sizes for the mini-float {E,M} to integer decoder.
// The integer width is derived from the exponent and mantissa widths and is never overridden.
package float2int_pkg;

  localparam int EW = 3;
  localparam int MW = 4;
  localparam int IW = MW + (1 << EW) - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef struct packed {
    logic [EW-1:0] e;
    logic [MW-1:0] m;
  } mini_float_t;

  // E == 0 is the denormal-like range, so only E != 0 requires a normalised mantissa.
  function automatic logic is_canonical(input logic [EW-1:0] e, input logic [MW-1:0] m);
    return (e == '0) || m[MW-1];
  endfunction

endpackage

// File: rtl/float2int_if.sv
// Input and output valid/ready channels of the float2int decoder.
// The master modport is the environment side and the slave modport is the decoder side.
interface float2int_if;

  logic                           in_valid;
  logic                           in_ready;
  logic [float2int_pkg::EW-1:0]   in_e;
  logic [float2int_pkg::MW-1:0]   in_m;
  logic                           out_valid;
  logic                           out_ready;
  logic [float2int_pkg::IW-1:0]   out_b;
  logic                           out_noncanon;

  modport master (
    output in_valid, in_e, in_m, out_ready,
    input  in_ready, out_valid, out_b, out_noncanon
  );

  modport slave (
    input  in_valid, in_e, in_m, out_ready,
    output in_ready, out_valid, out_b, out_noncanon
  );

endinterface

// File: rtl/float2int_shift_core.sv
// Accumulator/counter datapath: loads the mantissa, then shifts left once per cycle.
// With FLOAT2INT_BARREL_EN defined, the full M << E is loaded in one step.
module float2int_shift_core
  import float2int_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [EW-1:0] e_i,
  input  logic [MW-1:0] m_i,
  output logic [IW-1:0] acc_d_o,
  output logic          last_o
);

  logic [IW-1:0] acc_q, acc_d;
  logic [EW-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch appears.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
`ifdef FLOAT2INT_BARREL_EN
      acc_d = IW'(m_i) << e_i;
`else
      acc_d = IW'(m_i);
`endif
      cnt_d = e_i;
    end else if (shift_i) begin
      acc_d = acc_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_d_o = acc_d;
  assign last_o  = (cnt_q == EW'(1));

endmodule

// File: rtl/float2int_serial.sv
// Streaming mini-float {E,M} to integer decoder with valid/ready on both sides.
// Optional macro FLOAT2INT_BARREL_EN: single-cycle barrel shift, with no SHIFT state.
module float2int_serial
  import float2int_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  float2int_if.slave  io
);

  state_e        state_q;
  logic          out_valid_q;
  logic          noncanon_q;
  logic [IW-1:0] out_b_q;

  mini_float_t   in_word;
  logic          accept;
  logic          load_done;
  logic          last;
  logic [IW-1:0] acc_d;

  assign in_word  = '{e: io.in_e, m: io.in_m};
  // DONE can take a new word on the same edge that the current result retires.
  assign io.in_ready = (state_q == IDLE) || ((state_q == DONE) && io.out_ready);
  assign accept      = io.in_valid && io.in_ready;

`ifdef FLOAT2INT_BARREL_EN
  assign load_done = 1'b1;
`else
  assign load_done = (in_word.e == '0);
`endif

  float2int_shift_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .shift_i (state_q == SHIFT),
    .e_i     (in_word.e),
    .m_i     (in_word.m),
    .acc_d_o (acc_d),
    .last_o  (last)
  );

  // NOTE: the reset sits inside the clocked block, so it is synchronous and takes effect only on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_b_q     <= '0;
      noncanon_q  <= 1'b0;
    end else if (accept) begin
      noncanon_q <= !is_canonical(in_word.e, in_word.m);
      if (load_done) begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        out_b_q     <= acc_d;
      end else begin
        state_q     <= SHIFT;
        out_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_b_q     <= acc_d;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.out_valid    = out_valid_q;
  assign io.out_b        = out_b_q;
  assign io.out_noncanon = noncanon_q;

endmodule

// File: tb/tb_float2int_serial.sv
// Self-checking bench for float2int_serial. It runs directed cases first, then a random round trip
// through a behavioural int2float model.
module tb_float2int_serial;
  import float2int_pkg::*;

`ifdef FLOAT2INT_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  float2int_if io();

  float2int_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the decoded value is M * 2^E, and latency counts cycles from the accept edge.
  function automatic int ref_value(input int e, input int m);
    return m * (2 ** e);
  endfunction

  function automatic int ref_noncanon(input int e, input int m);
    return (e != 0 && m < 8) ? 1 : 0;
  endfunction

  function automatic int ref_latency(input int e);
    return BARREL ? 1 : e + 1;
  endfunction

  // int2float: normalise x into a 4-bit mantissa, truncating the low bits.
  function automatic mini_float_t int2float(input int x);
    int v = x;
    int e = 0;
    mini_float_t f;
    while (v >= 16) begin
      v = v / 2;
      e++;
    end
    f.e = e[EW-1:0];
    f.m = v[MW-1:0];
    return f;
  endfunction

  // Present one word, wait for its result, then optionally hold out_ready low for 'hold' cycles.
  // The task is entered and left on a falling edge.
  task automatic send(input int e, input int m, input int hold,
                      output int lat, output int b, output int nc, output int rdy_seen);
    int guard;
    io.in_valid  = 1'b1;
    io.in_e      = e[EW-1:0];
    io.in_m      = m[MW-1:0];
    io.out_ready = 1'b1;
    #1;
    guard = 0;
    while (!io.in_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("accept_ready", int'(io.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 0;
    while (!io.out_valid && lat < 20) begin
      if (io.in_ready) rdy_seen = 1;
      @(negedge clk);
      lat++;
    end
    b  = int'(io.out_b);
    nc = int'(io.out_noncanon);
    if (hold > 0) begin
      io.out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check("hold_b", int'(io.out_b), b);
        check("hold_valid", int'(io.out_valid), 1);
        check("hold_in_ready", int'(io.in_ready), 0);
      end
      io.out_ready = 1'b1;
    end
  endtask

  initial begin
    int lat, b, nc, rdy, seen;
    mini_float_t f;
    int x;

    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_e      = '0;
    io.in_m      = '0;
    io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(io.in_ready), 1);
    check("rst_out_valid", int'(io.out_valid), 0);
    check("rst_out_b", int'(io.out_b), 0);
    check("rst_noncanon", int'(io.out_noncanon), 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 15, 0, lat, b, nc, rdy);
    check("e0_lat", lat, ref_latency(0));
    check("e0_b", b, 15);
    check("e0_nc", nc, 0);

    send(7, 15, 0, lat, b, nc, rdy);
    check("e7_lat", lat, ref_latency(7));
    check("e7_b", b, 1920);
    check("e7_ready_low", rdy, 0);

    send(2, 3, 0, lat, b, nc, rdy);
    check("nc_b", b, 12);
    check("nc_flag", nc, 1);

    // Let the last result retire so the backpressure case starts from IDLE.
    @(negedge clk);
    send(4, 9, 5, lat, b, nc, rdy);
    check("bp_lat", lat, ref_latency(4));
    check("bp_b", b, 144);
    send(0, 5, 0, lat, b, nc, rdy);
    check("b2b_lat", lat, 1);
    check("b2b_b", b, 5);

    // Abort an in-flight word with reset on the third edge after it is accepted.
    io.in_valid  = 1'b1;
    io.in_e      = 3'd6;
    io.in_m      = 4'h8;
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(io.in_ready), 1);
    check("abort_out_valid", int'(io.out_valid), 0);
    check("abort_out_b", int'(io.out_b), 0);
    check("abort_noncanon", int'(io.out_noncanon), 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (io.out_valid) seen = 1;
    end
    check("abort_no_result", seen, 0);

    for (int i = 0; i < 80; i++) begin
      x = int'($urandom_range(0, 2047));
      f = int2float(x);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(int'(f.e), int'(f.m), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0,
           lat, b, nc, rdy);
      check("rt_b", b, ref_value(int'(f.e), int'(f.m)));
      check("rt_nc", nc, ref_noncanon(int'(f.e), int'(f.m)));
      check("rt_lat", lat, ref_latency(int'(f.e)));
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/float2int_serial.md
Name: float2int_serial

Overview:
- Streaming decoder from the 7-bit mini-float format {E[2:0], M[3:0]} back to an 11-bit unsigned integer: value = M << E.
- It is the inverse of the team's int2float encoder and is used in round-trip datapath checks and power experiments.
- Uses an iterative shifter, one bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- EW, 3, exponent width.
- MW, 4, mantissa width.
- IW, MW + 2**EW - 1 (=11), integer output width. Derived; never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_e  in  EW  exponent field.
- in_m  in  MW  mantissa field.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_b  out  IW  decoded integer.
- out_noncanon  out  1  input was non-canonical: E != 0 and M[MW-1] == 0.

Behaviour:
- Single clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_b = 0
  - out_noncanon = 0
  - internal counter and accumulator = 0
- Reset asserted mid-operation aborts any in-flight word; no output is produced for it.
- States:
  - IDLE: in_ready = 1.
  - SHIFT: in_ready = 0.
  - DONE: out_valid = 1; in_ready = out_ready.
- Accept occurs when in_valid & in_ready at a rising edge. On accept:
  - acc = zero-extended in_m; cnt = in_e.
  - noncanon flag registered.
  - Go to DONE if in_e == 0, else to SHIFT.
- SHIFT: each cycle acc <= acc << 1 and cnt <= cnt - 1. When cnt == 1, the last shift happens and the next state is DONE.
- Latency: out_valid rises E+1 cycles after the accept edge (E=0 gives 1 cycle, E=7 gives 8 cycles).
- Width: M<<E never exceeds IW bits (max 15<<7 = 1920). No truncation; no overflow logic.
- DONE:
  - out_b, out_valid and out_noncanon are held stable until out_ready.
  - out_ready & !in_valid: go to IDLE; out_valid clears next cycle.
  - out_ready & in_valid: back-to-back. The result is retired and the new word is accepted on the same edge, then the state goes to SHIFT or DONE according to the new E. Zero bubble when the new E is 0.
- out_b reflects acc only in DONE. In other states it holds its last value, and the bench must not check it.
- Non-canonical inputs still decode exactly as M<<E; they are only flagged.

Optional Feature:
- Macro: FLOAT2INT_BARREL_EN.
- Defined: the SHIFT state is removed and a combinational barrel shift loads acc = in_m << in_e at accept. The block always goes straight to DONE, so latency is 1 cycle for every E and throughput is 1 word/cycle when out_ready is held high.
- Undefined: iterative behaviour as above.
- Port list is identical in both builds.

Decomposition:
- Package float2int_pkg holds:
  - localparams EW, MW, IW
  - state enum typedef (IDLE, SHIFT, DONE)
  - typedef for the packed float {e, m}
  - function is_canonical(e, m)
- Natural sub-module: float2int_shift_core, holding the acc/cnt datapath with load/shift/done controls. The top module keeps the FSM and handshakes.

Test Plan:
- After reset, in_valid=1, E=3'd0, M=4'hF, out_ready=1 -> out_valid 1 cycle after accept, out_b=11'd15, out_noncanon=0.
- E=3'd7, M=4'hF -> out_valid exactly 8 cycles after accept, out_b=11'd1920; in_ready=0 throughout SHIFT.
- E=3'd2, M=4'h3 (non-canonical) -> out_b=11'd12, out_noncanon=1.
- Backpressure: E=3'd4, M=4'h9 with out_ready=0 for 5 cycles after out_valid -> out_b=11'd144 held stable and in_ready=0; releasing out_ready with in_valid=1, E=0, M=4'h5 -> the second result 11'd5 appears the very next cycle.
- Reset mid-operation: accept E=3'd6, M=4'h8, pull rst_n low on cycle 3 -> next cycle state IDLE, out_valid=0, out_b=0, and no result is ever produced for that word.
- Random round-trip against an int2float reference model: for every int2float output (E,M), out_b equals M<<E. With FLOAT2INT_BARREL_EN defined, every latency is 1.
